cla_share_arbiter: RTL and testbench
====================================

// Module: cla_share_arbiter
// PURPOSE
//   Shares one CLA_32bit adder instance among NUM_REQ requesters.
//   - Round-robin arbitration; one add in flight at a time.
//   - Operands and results are registered.
//   - Responses carry the requester ID and use a valid/ready handshake.
//   - Sits between the requesting blocks and the combinational CLA_32bit datapath.
// PARAMETERS
//   NUM_REQ   4    number of requesters (2..8)
//   ID_W      2    requester ID width, = clog2(NUM_REQ)
//   CNT_W     16   width of the completed-transaction counter
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            async, active-high reset
//   req_valid  in   NUM_REQ      request pending, one bit per requester
//   req_a      in   NUM_REQ*32   operand A; requester i uses [32*i+31:32*i]
//   req_b      in   NUM_REQ*32   operand B; same packing as req_a
//   req_ready  out  NUM_REQ      grant; one-hot or zero
//   rsp_valid  out  1            result available
//   rsp_ready  in   1            consumer accepts result
//   rsp_id     out  ID_W         requester that owns the result
//   rsp_sum    out  32           A+B, mod 2^32
//   rsp_cout   out  1            carry out of bit 31
//   busy       out  1            high when state != IDLE
//   txn_count  out  CNT_W        completed responses; wraps to 0
// BEHAVIOUR
//   Reset (async, immediate on rst=1), all outputs and state cleared:
//     - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0
//     - rsp_id=0, rsp_sum=0, rsp_cout=0, txn_count=0
//     - any in-flight operation is discarded; no response is issued.
//   FSM states: IDLE -> CALC -> DONE -> IDLE.
//   IDLE:
//     - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ...
//       mod NUM_REQ.
//     - req_ready[winner]=1, combinational, asserted in IDLE only.
//     - On handshake (valid & ready): latch op_a, op_b and id=winner;
//       rr_ptr <= (winner+1) mod NUM_REQ; go to CALC.
//     - No valid requests: stay in IDLE; rr_ptr unchanged.
//   CALC:
//     - CLA_32bit is driven from op_a/op_b.
//     - Register Sum->rsp_sum, Cout->rsp_cout, id->rsp_id.
//     - Set rsp_valid=1 and go to DONE.
//   DONE:
//     - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
//     - On rsp_ready=1: rsp_valid <= 0, txn_count += 1, go to IDLE.
//   Timing and throughput:
//     - Latency: accept at edge T -> rsp_valid=1 after edge T+1.
//     - Minimum 3 cycles per transaction.
//     - req_ready is 0 in CALC and DONE.
//   Requester behaviour:
//     - A requester holds req_valid and its operands until granted.
//     - Changing operands before the grant is allowed; the values latched
//       at the handshake are used.
//     - Dropping req_valid before the grant is allowed; no transaction occurs.
//   rsp_ready high in CALC has no effect.
//   rr_ptr wraps from NUM_REQ-1 to 0.
//   txn_count wraps from 2^CNT_W-1 to 0 with no flag.
//   Arithmetic is unsigned 32-bit; signed overflow is not reported.
// TESTING
//   1. Requester 0: A=10, B=20 -> rsp_sum=30, rsp_cout=0, rsp_id=0;
//      rsp_valid high 2 edges after the grant.
//   2. Requester 2: A=987654321, B=123456789 -> rsp_sum=1111111110,
//      rsp_cout=0, rsp_id=2.
//   3. Requester 1: A=32'hFFFFFFFF, B=1 -> rsp_sum=0, rsp_cout=1.
//   4. All 4 req_valid high, rsp_ready=1, 8 transactions ->
//      grant order 0,1,2,3,0,1,2,3; txn_count=8.
//   5. rsp_ready=0 for 5 cycles after a 123+456 result ->
//      rsp_sum=579 held stable; req_ready stays 0; one txn_count increment
//      when rsp_ready=1.
//   6. rst pulsed mid-CALC -> rsp_valid never asserts; rr_ptr=0,
//      txn_count=0; next request is served normally.

Source files
------------

// File: rtl/cla_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder among NUM_REQ requesters.
// One add in flight at a time; operands and results are registered, and results are returned with a valid/ready handshake.
module CLA_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout
);
    logic [31:0] g, p;
    logic [32:0] c;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;

    // Two-level lookahead: 4-bit groups, group carries chained from group G/P.
    always_comb begin
        g  = A & B;
        p  = A ^ B;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = Cin;
        for (int unsigned j = 0; j < 8; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int unsigned j = 0; j < 8; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        c[32] = gc[8];
        Sum   = p ^ c[31:0];
        Cout  = c[32];
    end
endmodule

module cla_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy,
    output logic [CNT_W-1:0]      txn_count
);
    localparam int unsigned NREQ = NUM_REQ;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]      rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;

    logic             found;
    logic [ID_W-1:0]  win, cand;
    logic [31:0]      cla_sum;
    logic             cla_cout;

    CLA_32bit u_cla (
        .A    (op_a_q),
        .B    (op_b_q),
        .Cin  (1'b0),
        .Sum  (cla_sum),
        .Cout (cla_cout)
    );

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Grant is held low while reset is asserted so reset truly clears req_ready.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found && !rst)
            req_ready[win] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        txn_count_d = txn_count_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    op_a_d   = req_a[32*win +: 32];
                    op_b_d   = req_b[32*win +: 32];
                    id_d     = win;
                    rr_ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                rsp_sum_d   = cla_sum;
                rsp_cout_d  = cla_cout;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != IDLE);
    assign txn_count = txn_count_q;
endmodule

// File: tb/tb_cla_share_arbiter.sv
// Bench for cla_share_arbiter: directed and random transactions compared against a round-robin/arithmetic reference model.
module tb_cla_share_arbiter;
    localparam int N  = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a, req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_sum;
    logic            rsp_cout, busy;
    logic [CW-1:0]   txn_count;

    int vectors     = 0;
    int miscompares = 0;
    int m_ptr       = 0;
    int m_txn       = 0;
    logic [31:0] opa[N];
    logic [31:0] opb[N];

    cla_share_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = opa[i];
            req_b[32*i +: 32] = opb[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input logic [N-1:0] mask, input int stall);
        int          w;
        logic [32:0] s;
        w = pick(mask);
        s = {1'b0, opa[w]} + {1'b0, opb[w]};
        req_valid = mask;
        drive_ops();
        rsp_ready = (stall == 0);
        #1;
        chk("grant_onehot", 64'(req_ready), 64'(1 << w));
        @(posedge clk);
        m_ptr = (w + 1) % N;
        @(negedge clk);
        opa[w] = ~opa[w];
        opb[w] = opb[w] + 32'd3;
        drive_ops();
        chk("calc_busy", 64'(busy), 64'(1));
        chk("calc_rsp_valid_low", 64'(rsp_valid), 64'(0));
        chk("calc_req_ready_low", 64'(req_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_sum", 64'(rsp_sum), 64'(s[31:0]));
        chk("rsp_cout", 64'(rsp_cout), 64'(s[32]));
        chk("rsp_id", 64'(rsp_id), 64'(w));
        chk("done_req_ready_low", 64'(req_ready), 64'(0));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_sum", 64'(rsp_sum), 64'(s[31:0]));
            chk("hold_id", 64'(rsp_id), 64'(w));
            chk("hold_req_ready", 64'(req_ready), 64'(0));
            chk("hold_txn_count", 64'(txn_count), 64'(m_txn));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        m_txn = (m_txn + 1) % (1 << CW);
        chk("accept_rsp_valid_low", 64'(rsp_valid), 64'(0));
        chk("accept_busy_low", 64'(busy), 64'(0));
        chk("txn_count", 64'(txn_count), 64'(m_txn));
    endtask

    // Request appears, then is withdrawn before the clock edge: no transaction.
    task automatic drop_step(input logic [N-1:0] mask);
        int w;
        w = pick(mask);
        req_valid = mask;
        drive_ops();
        #1;
        chk("drop_grant", 64'(req_ready), 64'(1 << w));
        req_valid = '0;
        #1;
        chk("drop_ready_low", 64'(req_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk("drop_busy_low", 64'(busy), 64'(0));
        chk("drop_txn_count", 64'(txn_count), 64'(m_txn));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
        chk("rst_txn_count", 64'(txn_count), 64'(0));
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        opa[0] = 32'd10;         opb[0] = 32'd20;        run_txn(4'b0001, 0);
        opa[2] = 32'd987654321;  opb[2] = 32'd123456789; run_txn(4'b0100, 0);
        opa[1] = 32'hFFFF_FFFF;  opb[1] = 32'd1;         run_txn(4'b0010, 1);
        opa[3] = 32'd7;          opb[3] = 32'd8;         run_txn(4'b1000, 0);

        for (int t = 0; t < 8; t++) begin
            rand_ops();
            run_txn(4'b1111, 0);
        end

        drop_step(4'b0110);

        for (int i = 0; i < N; i++) begin
            opa[i] = 32'd123;
            opb[i] = 32'd456;
        end
        run_txn(4'b1111, 5);

        for (int t = 0; t < 12; t++) begin
            rand_ops();
            if (t % 4 == 3) drop_step(N'($urandom_range(1, 15)));
            run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 2));
        end

        // Reset during CALC: the in-flight add is discarded.
        rand_ops();
        req_valid = 4'b0100;
        drive_ops();
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_txn_count", 64'(txn_count), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        m_txn = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("postrst_rsp_valid", 64'(rsp_valid), 64'(0));
        end
        rand_ops();
        run_txn(4'b1001, 1);
        for (int t = 0; t < 3; t++) begin
            rand_ops();
            run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
